// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment scan controller.
//   seg_state_e     : scan FSM states (OFF, ON, GUARD)
//   SEG_BLANK       : all-segments-off pattern
//   DEF_NUM_DIGITS  : default digit count
//   DEF_REFRESH_DIV : default clock cycles each digit stays lit
package seg_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ON    = 2'd1,
    ST_GUARD = 2'd2
  } seg_state_e;

  localparam logic [6:0] SEG_BLANK       = 7'b0000000;
  localparam int         DEF_NUM_DIGITS  = 4;
  localparam int         DEF_REFRESH_DIV = 50000;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: valid/ready load channel carrying a packed hex display value.
//   load_valid : source offers a new value (held until accepted)
//   load_value : nibble k drives digit k, digit 0 least significant
//   load_ready : sink staging buffer is empty
// Modports: master (value source), slave (scan controller).
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load_valid;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    load_ready;

  modport master (output load_valid, output load_value, input load_ready);
  modport slave  (input load_valid, input load_value, output load_ready);

endinterface

// File: rtl/hex2seg.sv
// hex2seg: combinational hex digit to 7-segment pattern decoder.
//   i_hex : 4-bit value 0..F
//   o_seg : active-high segments, bit 6 = a ... bit 0 = g
module hex2seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b0000000;
    case (i_hex)
      4'h0: o_seg = 7'b1111110;
      4'h1: o_seg = 7'b0110000;
      4'h2: o_seg = 7'b1101101;
      4'h3: o_seg = 7'b1111001;
      4'h4: o_seg = 7'b0110011;
      4'h5: o_seg = 7'b1011011;
      4'h6: o_seg = 7'b1011111;
      4'h7: o_seg = 7'b1110000;
      4'h8: o_seg = 7'b1111111;
      4'h9: o_seg = 7'b1111011;
      4'hA: o_seg = 7'b1110111;
      4'hB: o_seg = 7'b0011111;
      4'hC: o_seg = 7'b1001110;
      4'hD: o_seg = 7'b0111101;
      4'hE: o_seg = 7'b1001111;
      4'hF: o_seg = 7'b1000111;
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits.
// A value arrives over load_if, is staged in a pending buffer and copied into the
// displayed shadow only at a frame boundary (or at once while the display is off),
// so a frame never shows a mix of old and new digits. Each digit is lit for
// REFRESH_DIV cycles followed by one dark guard cycle against ghosting.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   enable     : 1 = scan, 0 = display off
//   load_if    : slave side of the valid/ready load channel
//   seg        : segment drive, active-high, bit 6 = a ... bit 0 = g (registered)
//   digit_en   : one-hot digit select, active-high (registered)
//   frame_done : one-cycle pulse at the end of the last digit's slot (registered)
// Optional build macro SEG_LZB_EN: leading-zero blanking of digits above digit 0.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg_scan_ctrl_if.slave        load_if,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);

  seg_state_e              r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [TICK_W-1:0]       r_tick;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic                    r_pend_vld;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic                    r_frame_done;

  logic [3:0]              w_nib;
  logic [6:0]              w_seg_dec;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_blank;
  logic                    w_boundary;
  logic                    w_commit;
  logic                    w_accept;

  assign load_if.load_ready = !r_pend_vld;
  assign seg        = r_seg;
  assign digit_en   = r_digit_en;
  assign frame_done = r_frame_done;

  // Guard cycle of the last digit while still enabled is the frame boundary.
  assign w_boundary = (r_state == ST_GUARD) && (r_idx == IDX_LAST) && enable;
  assign w_commit   = r_pend_vld && ((r_state == ST_OFF) || w_boundary);
  assign w_accept   = load_if.load_valid && !r_pend_vld;

  // Single shared decoder, fed by the nibble of the digit being scanned.
  always_comb begin
    w_nib    = 4'h0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_shadow[4*i +: 4];
        w_onehot[i] = 1'b1;
      end
    end
  end

  hex2seg u_hex2seg (
    .i_hex (w_nib),
    .o_seg (w_seg_dec)
  );

`ifdef SEG_LZB_EN
  // A digit above 0 is blanked when it and every more significant nibble are zero.
  always_comb begin
    w_blank = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if ((r_idx == IDX_W'(i)) && ((r_shadow >> (4*i)) == '0)) w_blank = 1'b1;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Staging and double-buffer: accept and commit never coincide, because
  // accept needs an empty pending buffer and commit needs a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_pending  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_commit) begin
        r_shadow   <= r_pending;
        r_pend_vld <= 1'b0;
      end
      if (w_accept) begin
        r_pending  <= load_if.load_value;
        r_pend_vld <= 1'b1;
      end
    end
  end

  // Scan FSM with registered outputs; outputs reflect the state before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_OFF;
      r_idx        <= '0;
      r_tick       <= '0;
      r_seg        <= SEG_BLANK;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= SEG_BLANK;
      r_digit_en   <= '0;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_OFF: begin
          r_idx  <= '0;
          r_tick <= '0;
          if (enable) r_state <= ST_ON;
        end
        ST_ON: begin
          if (!w_blank) begin
            r_seg      <= w_seg_dec;
            r_digit_en <= w_onehot;
          end
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_state <= ST_GUARD;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        ST_GUARD: begin
          r_idx        <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          r_frame_done <= (r_idx == IDX_LAST);
          r_state      <= ST_ON;
        end
        default: r_state <= ST_OFF;
      endcase
      // Disabling aborts the frame from any state without a frame_done pulse.
      if (!enable) begin
        r_state      <= ST_OFF;
        r_idx        <= '0;
        r_tick       <= '0;
        r_frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 4;
  localparam int F = N * (R + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [6:0]   seg;
  logic [N-1:0] digit_en;
  logic         frame_done;

  seg_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_if    (lif),
    .seg        (seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: c = number of consecutive enabled edges so far.
  // c == 0 means display off; otherwise the scan sits at frame offset (c-1) mod F,
  // where each digit owns R lit cycles followed by one dark cycle.
  int          c = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_pending = '0;
  bit          m_pv = 1'b0;
  logic [6:0]  e_seg = '0;
  logic [3:0]  e_den = '0;
  bit          e_fd = 1'b0;
  bit          chk_en = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        c = 0; m_shadow = '0; m_pending = '0; m_pv = 1'b0;
        e_seg = '0; e_den = '0; e_fd = 1'b0;
      end else begin
        bit pre_off, pre_lit, pre_last_gap, commit, accept, blank;
        int off, dig;
        pre_off      = (c == 0);
        off          = pre_off ? 0 : (c - 1) % F;
        dig          = off / (R + 1);
        pre_lit      = !pre_off && ((off % (R + 1)) < R);
        pre_last_gap = !pre_off && (off == F - 1);
        blank        = 1'b0;
`ifdef SEG_LZB_EN
        if (dig > 0 && (m_shadow >> (4 * dig)) == 16'h0) blank = 1'b1;
`endif
        e_seg = '0;
        e_den = '0;
        if (pre_lit && !blank) begin
          e_seg = tbl[m_shadow[4*dig +: 4]];
          e_den = 4'(1 << dig);
        end
        e_fd   = pre_last_gap && enable;
        commit = m_pv && (pre_off || (pre_last_gap && enable));
        accept = lif.load_valid && !m_pv;
        if (commit) begin m_shadow = m_pending; m_pv = 1'b0; end
        if (accept) begin m_pending = lif.load_value; m_pv = 1'b1; end
        c = enable ? c + 1 : 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("seg", 32'(seg), 32'(e_seg));
        chk("digit_en", 32'(digit_en), 32'(e_den));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("load_ready", 32'(lif.load_ready), 32'(!m_pv));
      end
    end
  end

  // Called at a negedge; holds valid until the DUT's ready is seen.
  task automatic do_load(input logic [15:0] v);
    int k = 0;
    lif.load_valid = 1'b1;
    lif.load_value = v;
    while (!lif.load_ready && k < 200) begin @(negedge clk); k++; end
    checks++;
    if (!lif.load_ready) begin
      failures++;
      $display("FAIL load_timeout actual=%0d required=1", lif.load_ready);
    end
    @(negedge clk);
    lif.load_valid = 1'b0;
  endtask

  task automatic wait_den(input logic [3:0] want, input string nm);
    int k = 0;
    while (digit_en !== want && k < 400) begin @(negedge clk); k++; end
    checks++;
    if (digit_en !== want) begin
      failures++;
      $display("FAIL %s_timeout actual=%b required=%b", nm, digit_en, want);
    end
  endtask

  task automatic wait_fd(input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (frame_done !== 1'b1 && k < 400);
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout actual=%b required=1", nm, frame_done);
    end
  endtask

  initial begin
    int k;
    bit xfer;
    lif.load_valid = 1'b0;
    lif.load_value = '0;
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h0);
    chk("rst_digit_en", 32'(digit_en), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_load_ready", 32'(lif.load_ready), 32'h1);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Load while off, then enable: digit0 shows 4 for R cycles, a gap, then 3.
    do_load(16'h1234);
    enable = 1'b1;
    wait_den(4'b0001, "first_d0");
    chk("d0_seg_4", 32'(seg), 32'b0110011);
    k = 0;
    while (digit_en === 4'b0001 && k < 50) begin k++; @(negedge clk); end
    chk("d0_lit_cycles", 32'(k), 32'd4);
    chk("dark_gap", 32'(digit_en), 32'h0);
    @(negedge clk);
    chk("d1_den", 32'(digit_en), 32'b0010);
    chk("d1_seg_3", 32'(seg), 32'b1111001);
    wait_fd("fd_a");
    k = 0;
    do begin @(negedge clk); k++; end while (frame_done !== 1'b1 && k < 100);
    chk("frame_period", 32'(k), 32'd20);

    // Mid-frame update stays staged until the boundary.
    wait_den(4'b0100, "d2_slot");
    do_load(16'hABCD);
    chk("staged_not_ready", 32'(lif.load_ready), 32'h0);
    wait_den(4'b1000, "d3_old");
    chk("old_frame_d3_1", 32'(seg), 32'b0110000);
    wait_fd("fd_b");
    chk("ready_after_bound", 32'(lif.load_ready), 32'h1);
    wait_den(4'b0001, "new_d0");
    chk("new_d0_D", 32'(seg), 32'b0111101);

    // Back-to-back loads: the second waits for ready.
    do_load(16'h1111);
    do_load(16'h2222);
    repeat (2 * F + 4) @(negedge clk);

    // Drop enable during digit2's slot.
    wait_den(4'b0100, "d2_drop");
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("off_den", 32'(digit_en), 32'h0);
    chk("off_seg", 32'(seg), 32'h0);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_den(4'b0001, "restart_d0");

`ifdef SEG_LZB_EN
    do_load(16'h0050);
    repeat (2 * F + 4) @(negedge clk);
    do_load(16'h0000);
    repeat (2 * F + 4) @(negedge clk);
`endif

    // Randomized traffic: enable toggles and loads with sparse nibbles.
    xfer = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (xfer) lif.load_valid = 1'b0;
      if (!lif.load_valid && $urandom_range(0, 9) == 0) begin
        lif.load_valid = 1'b1;
        lif.load_value = 16'($urandom) & 16'($urandom);
      end
      if ($urandom_range(0, 299) == 0) enable = !enable;
      xfer = lif.load_valid && lif.load_ready;
    end
    @(negedge clk);
    if (xfer) lif.load_valid = 1'b0;
    while (lif.load_valid && !lif.load_ready) @(negedge clk);
    @(negedge clk);
    lif.load_valid = 1'b0;

    // Asynchronous reset mid-slot with a staged value that must be lost.
    enable = 1'b1;
    wait_den(4'b0010, "pre_rst_d1");
    do_load(16'h9999);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(seg), 32'h0);
    chk("arst_den", 32'(digit_en), 32'h0);
    chk("arst_ready", 32'(lif.load_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_den(4'b0001, "post_rst_d0");
    chk("post_rst_d0_0", 32'(seg), 32'b1111110);
    repeat (F) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits driven through a single shared `hex2seg` decoder. It accepts a packed hex value over a valid/ready handshake and double-buffers it so updates take effect only at frame boundaries, which prevents tearing. It steps one digit at a time at a programmable refresh rate and inserts a one-cycle guard gap between digits to suppress ghosting. It sits between the register-file/debug datapath and the board display pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, 1..8
- `REFRESH_DIV`, 50000: clock cycles each digit is lit, ≥2
- `clk  input  1`: system clock, all logic on rising edge
- `rst_n  input  1`: reset, asynchronous, active-low
- `enable  input  1`: 1 = scan, 0 = display off
- `load_valid  input  1`: new display value offered
- `load_value  input  4*NUM_DIGITS`: nibble k drives digit k; digit 0 is least significant
- `load_ready  output  1`: pending buffer empty, value can be accepted
- `seg  output  7`: segment drive, active-high, bit 6 = a … bit 0 = g
- `digit_en  output  NUM_DIGITS`: one-hot digit select, active-high
- `frame_done  output  1`: one-cycle pulse when the last digit's slot ends

## Operation
- Registers:
  - `shadow`: displayed value.
  - `pending` and `pend_vld`: staged value.
  - `digit_idx`: current digit.
  - `tick_cnt`: 0..REFRESH_DIV-1.
  - FSM state.
- Reset values:
  - State OFF; `shadow`, `pending` = 0; `pend_vld` = 0; `digit_idx` = 0; `tick_cnt` = 0.
  - Outputs: `seg` = 0, `digit_en` = 0, `frame_done` = 0, `load_ready` = 1.
- Handshake:
  - `load_ready` = !`pend_vld` (combinational).
  - Transfer when `load_valid` && `load_ready`: `pending` ← `load_value`, `pend_vld` ← 1.
  - `load_valid` held with `load_ready` low is ignored and must stay asserted by the source.
- Commit:
  - At the frame boundary, or on any cycle in OFF, if `pend_vld` is set: `shadow` ← `pending`, `pend_vld` ← 0.
  - Commit uses pre-edge register contents. A value accepted on the boundary cycle stays in `pending` until the next boundary.
- FSM:
  - **OFF**: `digit_en` = 0, `seg` = 0, `tick_cnt` held at 0. Goes to ON when `enable` = 1.
  - **ON**: `digit_en` = one-hot(`digit_idx`); `seg` = decode(`shadow` nibble `digit_idx`); `tick_cnt` increments. When `tick_cnt` = REFRESH_DIV-1, clear `tick_cnt` and go to GUARD.
  - **GUARD** (exactly 1 cycle): `digit_en` = 0, `seg` = 0. `digit_idx` ← `digit_idx`+1, wrapping NUM_DIGITS-1 → 0. On wrap this cycle is the frame boundary: `frame_done` pulses and commit occurs. Then goes to ON.
  - `enable` = 0 in any state: next state is OFF; `digit_idx` and `tick_cnt` cleared. No `frame_done` pulse.
- Decode: one shared `hex2seg` instance; its input is muxed by `digit_idx`.
- `frame_done` is asserted on the GUARD cycle ending the slot of digit NUM_DIGITS-1.

## Timing
- `seg`, `digit_en`, `frame_done` are registered and reflect the state/index of the previous cycle, i.e. 1 cycle of latency from FSM state.
- `enable` 0→1: ON entered at edge 1; the first digit is lit on outputs from edge 2.
- Each digit is lit for REFRESH_DIV cycles, followed by 1 dark cycle. Frame period = NUM_DIGITS·(REFRESH_DIV+1) cycles.
- Accepted value is visible on `seg` in the first ON slot after the next boundary: at most one frame plus 2 cycles after acceptance. From OFF, commit happens on the next edge.
- Asynchronous reset mid-frame: all outputs are 0 immediately; any staged value is lost.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking. In the slot for digit k > 0, if nibbles k..NUM_DIGITS-1 of `shadow` are all 0, both `seg` and `digit_en` are 0 for that slot; slot timing is unchanged. Digit 0 is always displayed.
- `SEG_LZB_EN` undefined: every digit is displayed, including zeros. No blanking logic is synthesized.

## Structure
- Package `seg_pkg`:
  - FSM state enum (OFF, ON, GUARD).
  - `SEG_BLANK` = 7'b0000000.
  - Default `NUM_DIGITS` and `REFRESH_DIV` constants.
- Sub-module: the existing `hex2seg` decoder, instantiated once. The prescaler and FSM stay inline.

## Test plan
All scenarios use NUM_DIGITS=4 and REFRESH_DIV=4 unless stated.
- Reset with `enable`=1, `load_value`=16'h1234 accepted → digit0 shows 7'b0110011 (4) for 4 cycles, 1 dark cycle, then digit1 shows 7'b1111001 (3); frame repeats every 20 cycles.
- While 16'h1234 is displayed, load 16'hABCD mid-frame → `load_ready` is 0 until the boundary; the current frame completes with 1234; the next frame digit0 shows 7'b0111101 (D).
- Two back-to-back loads 16'h1111 then 16'h2222 → the second waits for `load_ready`; both values are displayed in successive frames, none dropped.
- `enable` dropped during the digit2 slot → outputs are 0 one cycle later. Re-enabling restarts at digit0 with no `frame_done` pulse for the aborted frame.
- With `SEG_LZB_EN` and value 16'h0050 → digits 3 and 2 are dark with `digit_en`=0; digit1 = 5, digit0 = 0. Value 16'h0000 → only digit0 is lit, showing 0.
- Async `rst_n` low mid-slot → `seg`, `digit_en` = 0 within the same cycle; after release, `shadow`=0 and 0000 is displayed.
